// File: rtl/port_ring_arb_pkg.sv
// Shared ring-arbiter definitions: port count, one-hot FSM encodings, clog2 helper.
// No logic; imported by port_ring_arb and rr_pick.
// No flow control; types and constants only.
package port_ring_arb_pkg;

    localparam int NUM_PORTS = 4;

    // Bit positions of the one-hot state encoding.
    localparam int ns_idle  = 0;
    localparam int ns_grant = 1;

    typedef enum logic [1:0] {
        s_idle  = 2'b01,
        s_grant = 2'b10
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority picker: first set request at or above ptr, wrapping.
// Latency: combinational.
// No flow control; any=0 when no request is pending.
module rr_pick
    import port_ring_arb_pkg::*;
#(
    parameter int n     = NUM_PORTS,
    parameter int idx_w = 2
) (
    input  logic [n-1:0]     req,
    input  logic [idx_w-1:0] ptr,
    output logic [n-1:0]     gnt,
    output logic [idx_w-1:0] idx,
    output logic             any
);

    logic [idx_w-1:0] cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int i = 0; i < n; i++) begin
            cand = idx_w'((int'(ptr) + i) % n);
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/port_ring_arb.sv
// Ring injection arbiter: one-hot round-robin grant held until owner EOP, withdrawal or watchdog.
// Latency: req->ack 1 cycle from idle; at least one ack-low cycle between grants.
// Owner holds ack until release; other ports wait, non-owner eop/req ignored while granted.
module port_ring_arb
    import port_ring_arb_pkg::*;
#(
    parameter int num_ports = NUM_PORTS,
    parameter int max_hold  = 0,
    parameter int hold_w    = 16,
    localparam int own_w    = (clog2(num_ports) < 1) ? 1 : clog2(num_ports)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [num_ports-1:0] rarb_req,
    input  logic [num_ports-1:0] rarb_eop,
    output logic [num_ports-1:0] rarb_ack,
    output logic                 rarb_timeout,
    output logic [own_w-1:0]     rarb_owner
);

    state_t               state_q, state_d;
    logic [num_ports-1:0] ack_q, ack_d;
    logic [own_w-1:0]     owner_q, owner_d;
    logic [own_w-1:0]     ptr_q, ptr_d;
    logic [hold_w-1:0]    hold_q, hold_d;
    logic                 timeout_q, timeout_d;

    logic [num_ports-1:0] pick_gnt;
    logic [own_w-1:0]     pick_idx;
    logic                 pick_any;
    logic                 wd_hit;
    logic                 own_eop;
    logic                 own_req;

    rr_pick #(
        .n     (num_ports),
        .idx_w (own_w)
    ) u_rr_pick (
        .req (rarb_req),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign own_eop = rarb_eop[owner_q];
    assign own_req = rarb_req[owner_q];
    assign wd_hit  = (max_hold != 0) && (hold_q == hold_w'(max_hold - 1));

    always_comb begin
        state_d   = state_q;
        ack_d     = ack_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        unique case (state_q)
            s_idle: begin
                if (pick_any) begin
                    ack_d   = pick_gnt;
                    owner_d = pick_idx;
                    ptr_d   = (pick_idx == own_w'(num_ports - 1)) ? '0 : pick_idx + 1'b1;
                    hold_d  = '0;
                    state_d = s_grant;
                end
            end
            s_grant: begin
                if (own_eop || !own_req || wd_hit) begin
                    ack_d     = '0;
                    state_d   = s_idle;
                    // A grant that ends normally on the same edge is not a reclaim.
                    timeout_d = wd_hit && !own_eop && own_req;
                end else begin
                    hold_d = (&hold_q) ? hold_q : hold_q + 1'b1;
                end
            end
            default: begin
                ack_d   = '0;
                state_d = s_idle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= s_idle;
            ack_q     <= '0;
            owner_q   <= '0;
            ptr_q     <= '0;
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ack_q     <= ack_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign rarb_ack     = ack_q;
    assign rarb_timeout = timeout_q;
    assign rarb_owner   = owner_q;

endmodule

// File: tb/tb_port_ring_arb.sv
// Directed bench for port_ring_arb (4 ports, 8-cycle watchdog).
module tb_port_ring_arb;

    logic       clk;
    logic       reset_n;
    logic [3:0] rarb_req;
    logic [3:0] rarb_eop;
    logic [3:0] rarb_ack;
    logic       rarb_timeout;
    logic [1:0] rarb_owner;

    int checks;
    int errors;

    port_ring_arb #(
        .num_ports (4),
        .max_hold  (8),
        .hold_w    (16)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rarb_req     (rarb_req),
        .rarb_eop     (rarb_eop),
        .rarb_ack     (rarb_ack),
        .rarb_timeout (rarb_timeout),
        .rarb_owner   (rarb_owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Grant must always be one-hot or idle.
    always @(negedge clk) begin
        checks++;
        if (!$onehot0(rarb_ack)) begin
            errors++;
            $display("FAIL onehot0: ack=%b required at most one bit set", rarb_ack);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset_n  = 1'b0;
        rarb_req = 4'b0000;
        rarb_eop = 4'b0000;
        tick;
        tick;
        reset_n = 1'b1;
    endtask

    task automatic test_reset;
        reset_n  = 1'b0;
        rarb_req = 4'b1111;
        rarb_eop = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++;
            if (rarb_ack !== 4'b0000 || rarb_timeout !== 1'b0 || rarb_owner !== 2'd0) begin
                errors++;
                $display("FAIL reset_hold: ack=%b to=%b owner=%0d required 0000/0/0",
                         rarb_ack, rarb_timeout, rarb_owner);
            end
        end
        reset_n = 1'b1;
        tick;
        checks++;
        if (rarb_ack !== 4'b0001 || rarb_owner !== 2'd0) begin
            errors++;
            $display("FAIL reset_first_grant: ack=%b owner=%0d required 0001/0", rarb_ack, rarb_owner);
        end
    endtask

    task automatic test_single;
        do_reset;
        rarb_req = 4'b0100;
        tick;
        checks++;
        if (rarb_ack !== 4'b0100 || rarb_owner !== 2'd2) begin
            errors++;
            $display("FAIL single_grant: ack=%b owner=%0d required 0100/2", rarb_ack, rarb_owner);
        end
        for (int i = 0; i < 4; i++) begin
            tick;
            checks++;
            if (rarb_ack !== 4'b0100) begin
                errors++;
                $display("FAIL single_hold: beat %0d ack=%b required 0100", i + 2, rarb_ack);
            end
        end
        rarb_eop = 4'b0100;
        tick;
        rarb_eop = 4'b0000;
        checks++;
        if (rarb_ack !== 4'b0000) begin
            errors++;
            $display("FAIL single_release: ack=%b required 0000", rarb_ack);
        end
        tick;
        checks++;
        if (rarb_ack !== 4'b0100) begin
            errors++;
            $display("FAIL single_regrant: ack=%b required 0100", rarb_ack);
        end
        rarb_req = 4'b0000;
        tick;
    endtask

    task automatic test_round_robin;
        int order [6];
        logic [3:0] exp;
        order = '{0, 1, 3, 0, 1, 3};
        do_reset;
        rarb_req = 4'b1011;
        for (int j = 0; j < 6; j++) begin
            exp = 4'b0001 << order[j];
            tick;
            checks++;
            if (rarb_ack !== exp || rarb_owner !== 2'(order[j])) begin
                errors++;
                $display("FAIL rr_grant: step %0d ack=%b owner=%0d required %b/%0d",
                         j, rarb_ack, rarb_owner, exp, order[j]);
            end
            rarb_eop = exp;
            tick;
            rarb_eop = 4'b0000;
            checks++;
            if (rarb_ack !== 4'b0000) begin
                errors++;
                $display("FAIL rr_gap: step %0d ack=%b required 0000", j, rarb_ack);
            end
        end
        rarb_req = 4'b0000;
        tick;
    endtask

    task automatic test_withdraw;
        do_reset;
        rarb_req = 4'b1010;
        tick;
        checks++;
        if (rarb_ack !== 4'b0010) begin
            errors++;
            $display("FAIL wd_grant1: ack=%b required 0010", rarb_ack);
        end
        tick;
        rarb_req = 4'b1000;
        tick;
        checks++;
        if (rarb_ack !== 4'b0000) begin
            errors++;
            $display("FAIL withdraw_release: ack=%b required 0000", rarb_ack);
        end
        tick;
        checks++;
        if (rarb_ack !== 4'b1000 || rarb_owner !== 2'd3) begin
            errors++;
            $display("FAIL withdraw_next: ack=%b owner=%0d required 1000/3", rarb_ack, rarb_owner);
        end
        rarb_req = 4'b0000;
        tick;
    endtask

    task automatic test_watchdog;
        do_reset;
        rarb_req = 4'b0011;
        for (int i = 0; i < 8; i++) begin
            tick;
            checks++;
            if (rarb_ack !== 4'b0001 || rarb_timeout !== 1'b0) begin
                errors++;
                $display("FAIL watchdog_hold: cycle %0d ack=%b to=%b required 0001/0",
                         i + 1, rarb_ack, rarb_timeout);
            end
        end
        tick;
        checks++;
        if (rarb_ack !== 4'b0000 || rarb_timeout !== 1'b1) begin
            errors++;
            $display("FAIL watchdog_reclaim: ack=%b to=%b required 0000/1", rarb_ack, rarb_timeout);
        end
        tick;
        checks++;
        if (rarb_ack !== 4'b0010 || rarb_timeout !== 1'b0 || rarb_owner !== 2'd1) begin
            errors++;
            $display("FAIL watchdog_next: ack=%b to=%b owner=%0d required 0010/0/1",
                     rarb_ack, rarb_timeout, rarb_owner);
        end
        rarb_req = 4'b0000;
        tick;
    endtask

    task automatic test_eop_at_timeout;
        do_reset;
        rarb_req = 4'b0001;
        for (int i = 0; i < 8; i++) begin
            tick;
        end
        checks++;
        if (rarb_ack !== 4'b0001) begin
            errors++;
            $display("FAIL eop_to_hold: ack=%b required 0001", rarb_ack);
        end
        rarb_eop = 4'b0001;
        tick;
        rarb_eop = 4'b0000;
        checks++;
        if (rarb_ack !== 4'b0000 || rarb_timeout !== 1'b0) begin
            errors++;
            $display("FAIL eop_to_release: ack=%b to=%b required 0000/0", rarb_ack, rarb_timeout);
        end
        rarb_req = 4'b0000;
        tick;
    endtask

    task automatic test_noise_reset;
        do_reset;
        rarb_req = 4'b1001;
        tick;
        checks++;
        if (rarb_ack !== 4'b0001) begin
            errors++;
            $display("FAIL noise_grant: ack=%b required 0001", rarb_ack);
        end
        rarb_eop = 4'b1000;
        tick;
        rarb_eop = 4'b0000;
        checks++;
        if (rarb_ack !== 4'b0001) begin
            errors++;
            $display("FAIL noise_ignored: ack=%b required 0001", rarb_ack);
        end
        reset_n = 1'b0;
        tick;
        checks++;
        if (rarb_ack !== 4'b0000 || rarb_owner !== 2'd0) begin
            errors++;
            $display("FAIL midgrant_reset: ack=%b owner=%0d required 0000/0", rarb_ack, rarb_owner);
        end
        reset_n = 1'b1;
        tick;
        checks++;
        if (rarb_ack !== 4'b0001) begin
            errors++;
            $display("FAIL ptr_reset: ack=%b required 0001", rarb_ack);
        end
        rarb_req = 4'b0000;
        tick;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset_n  = 1'b0;
        rarb_req = 4'b0000;
        rarb_eop = 4'b0000;
        test_reset;
        test_single;
        test_round_robin;
        test_withdraw;
        test_watchdog;
        test_eop_at_timeout;
        test_noise_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
